// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial LSB-first a - b - b_in through one full-subtractor cell and a borrow flip-flop
// Ports: clk/rst (async active-high); start, a, b, b_in are captured while ready=1;
// done pulses for one cycle with diff/b_out (and ovf when SERIAL_SUB_OVF_EN is defined) valid and held.
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             b_in,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             b_out
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_a_sr, r_b_sr;
  logic [WIDTH-2:0] r_d_sr;
  logic             r_br;
  logic [CW-1:0]    r_cnt;
  logic             w_x, w_y, w_d, w_br_next, w_last;
  logic [WIDTH-1:0] w_d_nxt;
  assign w_x       = r_a_sr[0];
  assign w_y       = r_b_sr[0];
  assign w_d       = w_x ^ w_y ^ r_br;
  assign w_br_next = (~w_x & w_y) | (~(w_x ^ w_y) & r_br);
  assign w_last    = r_cnt == CW'(WIDTH - 1);
  // the new bit enters at the MSB, so after WIDTH shifts the LSB sits at bit 0
  assign w_d_nxt   = {w_d, r_d_sr};
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  always_comb
    w_next = (r_state == IDLE) ? (start ? RUN : IDLE) :
             (r_state == RUN)  ? (w_last ? DONE : RUN) : IDLE;
  always_comb begin
    ready = r_state == IDLE;
    done  = r_state == DONE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_a_sr <= '0;
      r_b_sr <= '0;
      r_d_sr <= '0;
      r_br   <= 1'b0;
      r_cnt  <= '0;
      diff   <= '0;
      b_out  <= 1'b0;
    end else if (r_state == IDLE && start) begin
      r_a_sr <= a;
      r_b_sr <= b;
      r_br   <= b_in;
      r_cnt  <= '0;
    end else if (r_state == RUN) begin
      r_a_sr <= {1'b0, r_a_sr[WIDTH-1:1]};
      r_b_sr <= {1'b0, r_b_sr[WIDTH-1:1]};
      r_d_sr <= w_d_nxt[WIDTH-1:1];
      r_br   <= w_br_next;
      r_cnt  <= r_cnt + 1'b1;
      if (w_last) begin
        diff  <= w_d_nxt;
        b_out <= w_br_next;
      end
    end
`ifdef SERIAL_SUB_OVF_EN
  // on the last bit x, y, d are the operand and result sign bits
  always_ff @(posedge clk or posedge rst)
    if (rst)                           ovf <= 1'b0;
    else if (r_state == RUN && w_last) ovf <= (w_x ^ w_y) & (w_x ^ w_d);
`endif
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: table, random and corner-sequence checks of serial_subtractor
module tb_serial_subtractor;
  localparam int W = 4;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic         b_in = 1'b0;
  logic         ready, done, b_out;
  logic [W-1:0] diff;
  logic         ovf_v;
  int           n_chk = 0, n_fail = 0;
`ifdef SERIAL_SUB_OVF_EN
  logic ovf;
  assign ovf_v = ovf;
`else
  assign ovf_v = 1'b0;
`endif
  serial_subtractor #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .b_in(b_in),
    .ready(ready), .done(done), .diff(diff), .b_out(b_out)
`ifdef SERIAL_SUB_OVF_EN
    , .ovf(ovf)
`endif
  );
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
  typedef struct {
    logic [W-1:0] a, b;
    logic         bi;
    logic [W-1:0] d;
    logic         bo, ov;
  } vec_t;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  // reference: plain integer arithmetic on the operand values
  task automatic model(input logic [W-1:0] ma, mb, input logic mbi,
                       output logic [W-1:0] md, output logic mbo, output logic mov);
    int sa, sb, r;
    md  = W'(int'(ma) - int'(mb) - int'(mbi));
    mbo = int'(ma) < int'(mb) + int'(mbi);
    sa  = ma[W-1] ? int'(ma) - (1 << W) : int'(ma);
    sb  = mb[W-1] ? int'(mb) - (1 << W) : int'(mb);
    r   = sa - sb - int'(mbi);
    mov = (r < -(1 << (W - 1))) || (r > (1 << (W - 1)) - 1);
  endtask
  task automatic check_res(input string name, input logic [W-1:0] ed, input logic ebo, input logic eov);
    chk({name, ".diff"}, 32'(diff), 32'(ed));
    chk({name, ".b_out"}, 32'(b_out), 32'(ebo));
`ifdef SERIAL_SUB_OVF_EN
    chk({name, ".ovf"}, 32'(ovf_v), 32'(eov));
`else
    if (eov === 1'bx) chk({name, ".ovf"}, 32'(ovf_v), 32'(eov));
`endif
  endtask
  // one full operation with exact latency checks on done/ready
  task automatic do_op(input string name, input logic [W-1:0] ta, tb, input logic tbi);
    logic [W-1:0] ed;
    logic ebo, eov;
    model(ta, tb, tbi, ed, ebo, eov);
    @(negedge clk);
    a = ta; b = tb; b_in = tbi; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); b_in = 1'($urandom);
    chk({name, ".busy"}, 32'(ready), 0);
    for (int k = 1; k <= W; k++) begin
      @(posedge clk); #1;
      chk({name, ".done"}, 32'(done), (k == W) ? 1 : 0);
    end
    check_res(name, ed, ebo, eov);
    @(posedge clk); #1;
    chk({name, ".done_end"}, 32'(done), 0);
    chk({name, ".ready_back"}, 32'(ready), 1);
  endtask
  initial begin
    vec_t vt[8];
    logic [W-1:0] ed;
    logic ebo, eov;
    int ndone;
    vt[0] = '{4'b1001, 4'b0011, 1'b0, 4'b0110, 1'b0, 1'b1};
    vt[1] = '{4'b0011, 4'b1001, 1'b0, 4'b1010, 1'b1, 1'b1};
    vt[2] = '{4'b0000, 4'b0000, 1'b1, 4'b1111, 1'b1, 1'b0};
    vt[3] = '{4'b0111, 4'b1111, 1'b0, 4'b1000, 1'b1, 1'b1};
    vt[4] = '{4'b0110, 4'b0001, 1'b0, 4'b0101, 1'b0, 1'b0};
    vt[5] = '{4'b1111, 4'b1111, 1'b1, 4'b1111, 1'b1, 1'b0};
    vt[6] = '{4'b1000, 4'b0001, 1'b0, 4'b0111, 1'b0, 1'b1};
    vt[7] = '{4'b0101, 4'b0101, 1'b0, 4'b0000, 1'b0, 1'b0};
    #12;
    chk("rst.ready", 32'(ready), 1);
    chk("rst.done", 32'(done), 0);
    check_res("rst", '0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      do_op($sformatf("vec%0d", i), vt[i].a, vt[i].b, vt[i].bi);
      check_res($sformatf("vec%0d.tbl", i), vt[i].d, vt[i].bo, vt[i].ov);
    end
    for (int i = 0; i < 40; i++)
      do_op($sformatf("rnd%0d", i), W'($urandom), W'($urandom), 1'($urandom));
    // start held high: operands changing during RUN must be ignored
    @(negedge clk);
    a = 4'b1001; b = 4'b0011; b_in = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    ndone = 0;
    for (int k = 1; k <= W + 1; k++) begin
      if (k <= W) begin a = W'($urandom); b = W'($urandom); b_in = 1'($urandom); end
      else        begin a = '0; b = '0; b_in = 1'b1; end
      @(posedge clk); #1;
      ndone += int'(done);
      if (k == W) check_res("hold1", 4'b0110, 1'b0, 1'b1);
      if (k <= W) chk("hold1.busy", 32'(ready), 0);
    end
    chk("hold1.ndone", 32'(ndone), 1);
    chk("hold1.ready", 32'(ready), 1);
    @(posedge clk); #1;
    ndone = 0;
    for (int k = 1; k <= W; k++) begin
      a = W'($urandom); b = W'($urandom); b_in = 1'($urandom);
      @(posedge clk); #1;
      ndone += int'(done);
    end
    start = 1'b0;
    chk("hold2.done", 32'(done), 1);
    chk("hold2.ndone", 32'(ndone), 1);
    check_res("hold2", 4'b1111, 1'b1, 1'b0);
    @(posedge clk); #1;
    // reset two edges into RUN discards the operation
    @(negedge clk);
    a = 4'b0011; b = 4'b1001; b_in = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    #2;
    chk("midrst.ready_async", 32'(ready), 1);
    @(negedge clk);
    rst = 1'b0;
    chk("midrst.ready", 32'(ready), 1);
    chk("midrst.done", 32'(done), 0);
    check_res("midrst", '0, 1'b0, 1'b0);
    ndone = 0;
    for (int k = 0; k < W + 3; k++) begin
      @(posedge clk); #1;
      ndone += int'(done);
    end
    chk("midrst.nodone", 32'(ndone), 0);
    check_res("midrst.hold", '0, 1'b0, 1'b0);
    do_op("after_rst", 4'b1001, 4'b0011, 1'b0);
    model(4'b1001, 4'b0011, 1'b0, ed, ebo, eov);
    chk("after_rst.model", 32'(diff), 32'(ed));
    // results stay stable while idle
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("idle.hold", 32'(diff), 32'(4'b0110));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
